// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and video bus widths.
// Also imported by the pixel generator for the active-area size.
package vga_timing_pkg;

   localparam int unsigned RgbW   = 24;  // RGB888
   localparam int unsigned CoordW = 10;  // counters and coordinates; totals must stay <= 1024

   localparam int unsigned DefHSync  = 96;
   localparam int unsigned DefHBack  = 48;
   localparam int unsigned DefHDisp  = 640;
   localparam int unsigned DefHFront = 16;
   localparam int unsigned DefHTotal = DefHSync + DefHBack + DefHDisp + DefHFront;

   localparam int unsigned DefVSync  = 2;
   localparam int unsigned DefVBack  = 33;
   localparam int unsigned DefVDisp  = 480;
   localparam int unsigned DefVFront = 10;
   localparam int unsigned DefVTotal = DefVSync + DefVBack + DefVDisp + DefVFront;

   localparam bit DefSyncPol = 1'b0;  // active-low syncs

endpackage

// File: rtl/vga_driver.sv
// VGA timing generator: line/frame counters, sync/DE decode, one-clock-early
// pixel coordinate requests and DE gating of the returned pixel data.
module vga_driver
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_SYNC   = DefHSync,
   parameter int unsigned H_BACK   = DefHBack,
   parameter int unsigned H_DISP   = DefHDisp,
   parameter int unsigned H_FRONT  = DefHFront,
   parameter int unsigned H_TOTAL  = DefHTotal,
   parameter int unsigned V_SYNC   = DefVSync,
   parameter int unsigned V_BACK   = DefVBack,
   parameter int unsigned V_DISP   = DefVDisp,
   parameter int unsigned V_FRONT  = DefVFront,
   parameter int unsigned V_TOTAL  = DefVTotal,
   parameter bit          SYNC_POL = DefSyncPol
) (
   input  logic              vga_clk,
   input  logic              sys_rst_n,
   input  logic [RgbW-1:0]   pixel_data,
   output logic [CoordW-1:0] pixel_xpos,
   output logic [CoordW-1:0] pixel_ypos,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_de,
   output logic [RgbW-1:0]   vga_rgb
);

   // Window bounds, all half-open [start, end), pre-sized to the counter width.
   localparam logic [CoordW-1:0] HLast     = CoordW'(H_TOTAL - 1);
   localparam logic [CoordW-1:0] VLast     = CoordW'(V_TOTAL - 1);
   localparam logic [CoordW-1:0] HSyncEnd  = CoordW'(H_SYNC);
   localparam logic [CoordW-1:0] VSyncEnd  = CoordW'(V_SYNC);
   localparam logic [CoordW-1:0] HActStart = CoordW'(H_SYNC + H_BACK);
   localparam logic [CoordW-1:0] HActEnd   = CoordW'(H_SYNC + H_BACK + H_DISP);
   // Requests lead the visible pixel by one clock to cover the generator's register.
   localparam logic [CoordW-1:0] HReqStart = CoordW'(H_SYNC + H_BACK - 1);
   localparam logic [CoordW-1:0] HReqEnd   = CoordW'(H_SYNC + H_BACK + H_DISP - 1);
   localparam logic [CoordW-1:0] VActStart = CoordW'(V_SYNC + V_BACK);
   localparam logic [CoordW-1:0] VActEnd   = CoordW'(V_SYNC + V_BACK + V_DISP);

   logic [CoordW-1:0] cnt_h_q, cnt_h_d;
   logic [CoordW-1:0] cnt_v_q, cnt_v_d;
   logic              h_act, v_act, data_req;

   // Next-state: column counter every clock, row counter at end of each line.
   always_comb begin
      cnt_h_d = cnt_h_q + 1'b1;
      cnt_v_d = cnt_v_q;
      if (cnt_h_q == HLast) begin
         cnt_h_d = '0;
         cnt_v_d = (cnt_v_q == VLast) ? '0 : cnt_v_q + 1'b1;
      end
   end

   // Counter registers with synchronous active-low reset.
   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         cnt_h_q <= '0;
         cnt_v_q <= '0;
      end else begin
         cnt_h_q <= cnt_h_d;
         cnt_v_q <= cnt_v_d;
      end
   end

   // Output decode straight from the counters; no output registers.
   always_comb begin
      h_act    = (cnt_h_q >= HActStart) && (cnt_h_q < HActEnd);
      v_act    = (cnt_v_q >= VActStart) && (cnt_v_q < VActEnd);
      data_req = (cnt_h_q >= HReqStart) && (cnt_h_q < HReqEnd) && v_act;

      vga_hs = (cnt_h_q < HSyncEnd) ? SYNC_POL : ~SYNC_POL;
      vga_vs = (cnt_v_q < VSyncEnd) ? SYNC_POL : ~SYNC_POL;
      vga_de = h_act && v_act;

      pixel_xpos = data_req ? cnt_h_q - HReqStart : '0;
      pixel_ypos = data_req ? cnt_v_q - VActStart : '0;
      vga_rgb    = vga_de ? pixel_data : '0;
   end

endmodule

// File: tb/tb_vga_driver.sv
// Scoreboard bench for vga_driver: a full-size 640x480 instance and a shrunken
// positive-sync instance run side by side against a frame-position model.
module tb_vga_driver;
   import vga_timing_pkg::*;

   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic        hs;
      logic        vs;
      logic        de;
      logic [23:0] rgb;
   } obs_t;

   typedef struct {
      int hs, hb, hd, hf, vs, vb, vd, vf;
      bit pol;
   } tim_t;

   localparam int NumCycles = 29700;
   // Directed mid-frame reset on the full-size instance: line 36, column 400.
   localparam int DefResetT = 36 * 800 + 400;

   logic        vga_clk = 1'b0;
   logic        sys_rst_n [2];
   logic [23:0] pix       [2];
   logic [9:0]  xpos      [2];
   logic [9:0]  ypos      [2];
   logic        hs        [2];
   logic        vs        [2];
   logic        de        [2];
   logic [23:0] rgb       [2];

   obs_t sb0[$];
   obs_t sb1[$];
   tim_t tim[2];
   bit   drv_done = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 vga_clk = ~vga_clk;

   vga_driver u_dut_full (
      .vga_clk    (vga_clk),
      .sys_rst_n  (sys_rst_n[0]),
      .pixel_data (pix[0]),
      .pixel_xpos (xpos[0]),
      .pixel_ypos (ypos[0]),
      .vga_hs     (hs[0]),
      .vga_vs     (vs[0]),
      .vga_de     (de[0]),
      .vga_rgb    (rgb[0])
   );

   vga_driver #(
      .H_SYNC   (8),
      .H_BACK   (4),
      .H_DISP   (20),
      .H_FRONT  (4),
      .H_TOTAL  (36),
      .V_SYNC   (2),
      .V_BACK   (3),
      .V_DISP   (10),
      .V_FRONT  (2),
      .V_TOTAL  (17),
      .SYNC_POL (1'b1)
   ) u_dut_small (
      .vga_clk    (vga_clk),
      .sys_rst_n  (sys_rst_n[1]),
      .pixel_data (pix[1]),
      .pixel_xpos (xpos[1]),
      .pixel_ypos (ypos[1]),
      .vga_hs     (hs[1]),
      .vga_vs     (vs[1]),
      .vga_de     (de[1]),
      .vga_rgb    (rgb[1])
   );

   // Pixel-generator pattern; the top nibble is never zero so DE gating is visible.
   function automatic logic [23:0] pattern(logic [9:0] x, logic [9:0] y, logic [23:0] salt);
      return {4'hA, y, x} ^ salt;
   endfunction

   function automatic int frame_len(tim_t p);
      return (p.hs + p.hb + p.hd + p.hf) * (p.vs + p.vb + p.vd + p.vf);
   endfunction

   // Expected outputs for a given position t (clocks since frame start).
   function automatic obs_t model(tim_t p, int t, logic [23:0] salt);
      obs_t o;
      int   ht, x, ln, h0, v0;
      bit   von, de_n, req;
      ht   = p.hs + p.hb + p.hd + p.hf;
      x    = t % ht;
      ln   = t / ht;
      h0   = p.hs + p.hb;
      v0   = p.vs + p.vb;
      von  = (ln >= v0) && (ln < v0 + p.vd);
      de_n = (x >= h0) && (x < h0 + p.hd) && von;
      req  = (x + 1 >= h0) && (x + 1 < h0 + p.hd) && von;
      o.hs  = (x < p.hs) ? p.pol : ~p.pol;
      o.vs  = (ln < p.vs) ? p.pol : ~p.pol;
      o.de  = de_n;
      o.x   = req ? 10'(x + 1 - h0) : 10'd0;
      o.y   = req ? 10'(ln - v0) : 10'd0;
      o.rgb = de_n ? pattern(10'(x - h0), 10'(ln - v0), salt) : 24'd0;
      return o;
   endfunction

   // Stimulus: resets, registered pixel data, and expected-value pushes.
   initial begin
      int          t       [2];
      bit          rst_edge[2];
      logic [9:0]  cx      [2];
      logic [9:0]  cy      [2];
      logic [23:0] salt    [2];
      int          hold;
      tim[0] = '{96, 48, 640, 16, 2, 33, 480, 10, 1'b0};
      tim[1] = '{8, 4, 20, 4, 2, 3, 10, 2, 1'b1};
      hold   = 0;
      for (int i = 0; i < 2; i++) begin
         salt[i]      = {4'h5, 20'($urandom)};
         sys_rst_n[i] = 1'b0;
         pix[i]       = 24'd0;
         rst_edge[i]  = 1'b0;
         t[i]         = 0;
         cx[i]        = 10'd0;
         cy[i]        = 10'd0;
      end
      @(posedge vga_clk);
      #1;
      for (int k = 0; k < NumCycles; k++) begin
         for (int i = 0; i < 2; i++) begin
            t[i]   = rst_edge[i] ? (t[i] + 1) % frame_len(tim[i]) : 0;
            pix[i] = pattern(cx[i], cy[i], salt[i]);
            if (i == 0) sb0.push_back(model(tim[i], t[i], salt[i]));
            else        sb1.push_back(model(tim[i], t[i], salt[i]));
         end
         sys_rst_n[0] = !((k == 0) || (t[0] == DefResetT));
         if (k == 0) begin
            sys_rst_n[1] = 1'b0;
         end else if (hold > 0) begin
            sys_rst_n[1] = 1'b0;
            hold--;
         end else if ($urandom_range(0, 699) == 0) begin
            sys_rst_n[1] = 1'b0;
            hold = $urandom_range(0, 2);
         end else begin
            sys_rst_n[1] = 1'b1;
         end
         for (int i = 0; i < 2; i++) rst_edge[i] = sys_rst_n[i];
         @(negedge vga_clk);
         for (int i = 0; i < 2; i++) begin
            cx[i] = xpos[i];
            cy[i] = ypos[i];
         end
         @(posedge vga_clk);
         #1;
      end
      drv_done = 1'b1;
   end

   // Monitor: every clock both instances present outputs; pop and compare.
   initial begin
      obs_t got, exp;
      for (int k = 0; k < NumCycles + 4; k++) begin
         @(negedge vga_clk);
         for (int i = 0; i < 2; i++) begin
            got = {xpos[i], ypos[i], hs[i], vs[i], de[i], rgb[i]};
            if ((i == 0 ? sb0.size() : sb1.size()) == 0) begin
               if (!drv_done) begin
                  total++;
                  bad++;
                  $display("FAIL no_expected cyc=%0d inst=%0d", k, i);
               end
            end else begin
               exp = (i == 0) ? sb0.pop_front() : sb1.pop_front();
               total++;
               if (got !== exp) begin
                  bad++;
                  $display({"FAIL outputs cyc=%0d inst=%0d got x=%0d y=%0d hs=%b vs=%b de=%b ",
                            "rgb=%h want x=%0d y=%0d hs=%b vs=%b de=%b rgb=%h"},
                           k, i, got.x, got.y, got.hs, got.vs, got.de, got.rgb,
                           exp.x, exp.y, exp.hs, exp.vs, exp.de, exp.rgb);
               end
            end
         end
      end
      total++;
      if (sb0.size() + sb1.size() != 0) begin
         bad++;
         $display("FAIL leftover got=%0d want=0", sb0.size() + sb1.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
